serial_line_broadcaster: RTL
============================

// Module: serial_line_broadcaster
// PURPOSE
//  Clocked, parametrised successor to the combinational serial multibroadcaster.
//  Receives framed serial data: start bit, then port/line address header, then PLEN payload bits.
//  Routes the payload, registered, to exactly one line of one enabled port.
//  Sits between the serial front end and the per-port line drivers.
// PARAMETERS
//  NPORT  4  number of ports (>=2); PW = $clog2(NPORT)
//  NLINE  4  lines per port (>=2); LW = $clog2(NLINE)
//  PLEN   8  payload bits per frame (>=1)
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            async active-low reset
//  ser_in    in   1            serial data, idle low, MSB first
//  port_en   in   NPORT        per-port enable, sampled on last header bit
//  lout      out  NPORT*NLINE  line outputs, index p*NLINE+l
//  lout_act  out  NPORT*NLINE  marks line currently carrying payload (one-hot or 0)
//  busy      out  1            frame in progress (state != IDLE)
//  done      out  1            1-cycle pulse: frame delivered
//  err       out  1            1-cycle pulse: frame dropped
// BEHAVIOUR
//  Reset: state=IDLE; lout, lout_act, busy, done, err all 0; counters 0. Reset mid-frame loses the frame.
//  FSM: IDLE -> HDR when ser_in=1 (start bit).
//  HDR: shift PW port bits then LW line bits (MSB first).
//  On last header bit, decode. Port disabled or port>=NPORT or line>=NLINE -> DROP; else -> DATA with sel latched.
//  DATA: PLEN cycles; lout[sel] <= ser_in, lout_act[sel] <= 1; all other lout/lout_act bits 0.
//  Latency: each payload bit is on lout one cycle after it is sampled.
//  Last payload bit sampled -> IDLE; done=1 in the cycle that bit is on lout.
//  Next cycle lout/lout_act return to 0 unless a new frame is in DATA.
//  DROP: consume PLEN bits with all outputs 0, then IDLE; err=1 in the cycle after the last bit.
//  Back-to-back: a start bit is accepted in the first IDLE cycle after DATA/DROP.
//  port_en and ser_in changes during DATA/DROP do not affect the routing of the current frame.
//  Bit counter is $clog2(PLEN+1) wide and saturates/clears on each state change; no wrap inside a frame.
// CONFIGURATION
//  Macro SLB_BROADCAST_EN.
//  Defined: header carries one extra mode bit after the line bits.
//   mode=1 -> payload drives all NLINE lines of the selected port; lout_act marks all of them; line address ignored.
//   mode=0 -> unicast as above.
//  Undefined: no mode bit; header is PW+LW bits; unicast only.
// STRUCTURE
//  Package slb_pkg: state enum {IDLE,HDR,DATA,DROP}; function clog2_min1(n) returns max(1,$clog2(n)).
//  Sub-module slb_frame_rx: start detect, header shift register, bit counter, decode;
//   outputs sel_port, sel_line, (mode), hdr_ok, hdr_bad.
//  Top: FSM, output demux registers, done/err pulses.
// TESTING (NPORT=4, NLINE=4, PLEN=8, port_en=4'hF unless stated)
//  Reset mid-frame: assert rst_n=0 after 3 payload bits -> all outputs 0 immediately; next frame decodes normally.
//  Unicast: ser_in 1,1,0,0,1 then 8'hA5 -> lout[9] = 1,0,1,0,0,1,0,1 on successive cycles;
//   lout_act[9]=1 for 8 cycles, others 0; done on 8th.
//  Disabled port: port_en=4'b1011, header port=2 -> DROP, lout stays 0, err pulse 1 cycle after 8th payload bit.
//  Back-to-back: two frames (p0,l3,8'hFF) and (p3,l0,8'h01) with start bit right after first payload
//   -> lout[3] then lout[12] correct; two done pulses.
//  port_en toggled to 0 during DATA -> current frame still delivered in full.
//  SLB_BROADCAST_EN: header p1, mode=1, payload 8'h81 -> lout[4..7] all show 1,0,0,0,0,0,0,1; lout_act=16'h00F0.

Source files
------------

// File: rtl/slb_pkg.sv
// slb_pkg: shared state encoding and width helper for the serial line broadcaster
package slb_pkg;
   typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/slb_frame_rx.sv
// slb_frame_rx: header shift register, bit counter and header decode
// SLB_BROADCAST_EN adds a trailing mode bit to the header.
module slb_frame_rx
   import slb_pkg::*;
#(
   parameter int NPORT = 4,
   parameter int NLINE = 4,
   parameter int PLEN = 8,
   localparam int PW = clog2_min1(NPORT),
   localparam int LW = clog2_min1(NLINE)
) (
   input logic clk,
   input logic rst_n,
   input logic ser_in,
   input state_t state,
   input logic [NPORT-1:0] port_en,
   output logic [PW-1:0] sel_port,
   output logic [LW-1:0] sel_line,
   output logic mode,
   output logic hdr_ok,
   output logic hdr_bad,
   output logic pay_last
);
`ifdef SLB_BROADCAST_EN
   localparam int HW = PW + LW + 1;
`else
   localparam int HW = PW + LW;
`endif
   localparam int CW = clog2_min1(((PLEN > HW) ? PLEN : HW) + 1);
   logic [CW-1:0] cnt;
   logic [HW-2:0] shreg;
   logic [HW-1:0] hdr;
   logic [NPORT-1:0] en_sh;
   logic hdr_last, valid;
   // decode sees the full header including the bit arriving this cycle
   always_comb begin
      hdr = {shreg, ser_in};
      sel_port = hdr[HW-1 -: PW];
      sel_line = hdr[HW-1-PW -: LW];
`ifdef SLB_BROADCAST_EN
      mode = hdr[0];
`else
      mode = 1'b0;
`endif
      en_sh = port_en >> sel_port;
      hdr_last = state == HDR && cnt == CW'(HW - 1);
      pay_last = (state == DATA || state == DROP) && cnt == CW'(PLEN - 1);
      valid = en_sh[0] && 32'(sel_port) < NPORT && (mode || 32'(sel_line) < NLINE);
      hdr_ok = hdr_last && valid;
      hdr_bad = hdr_last && !valid;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         shreg <= '0;
      end else begin
         cnt <= (state == IDLE || hdr_last || pay_last) ? '0 : (&cnt ? cnt : cnt + 1'b1);
         if (state == HDR) shreg <= hdr[HW-2:0];
      end
endmodule

// File: rtl/serial_line_broadcaster.sv
// serial_line_broadcaster: routes framed serial payload to one line (or one port with SLB_BROADCAST_EN)
// Frame: start bit, port bits, line bits, [mode bit], PLEN payload bits, all MSB first.
module serial_line_broadcaster
   import slb_pkg::*;
#(
   parameter int NPORT = 4,
   parameter int NLINE = 4,
   parameter int PLEN = 8
) (
   input logic clk,
   input logic rst_n,
   input logic ser_in,
   input logic [NPORT-1:0] port_en,
   output logic [NPORT*NLINE-1:0] lout,
   output logic [NPORT*NLINE-1:0] lout_act,
   output logic busy,
   output logic done,
   output logic err
);
   localparam int PW = clog2_min1(NPORT);
   localparam int LW = clog2_min1(NLINE);
   localparam int N = NPORT * NLINE;
   state_t state;
   logic [PW-1:0] sel_port, port_q;
   logic [LW-1:0] sel_line, line_q;
   logic mode, mode_q, hdr_ok, hdr_bad, pay_last;
   logic [N-1:0] mask;
   slb_frame_rx #(.NPORT(NPORT), .NLINE(NLINE), .PLEN(PLEN)) u_rx (
      .clk(clk),
      .rst_n(rst_n),
      .ser_in(ser_in),
      .state(state),
      .port_en(port_en),
      .sel_port(sel_port),
      .sel_line(sel_line),
      .mode(mode),
      .hdr_ok(hdr_ok),
      .hdr_bad(hdr_bad),
      .pay_last(pay_last)
   );
   always_comb
      mask = mode_q ? N'({NLINE{1'b1}}) << (32'(port_q) * NLINE)
                    : N'(1) << (32'(port_q) * NLINE + 32'(line_q));
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         port_q <= '0;
         line_q <= '0;
         mode_q <= 1'b0;
         lout <= '0;
         lout_act <= '0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         lout <= '0;
         lout_act <= '0;
         done <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (ser_in) state <= HDR;
            HDR:
               if (hdr_ok) begin
                  state <= DATA;
                  port_q <= sel_port;
                  line_q <= sel_line;
                  mode_q <= mode;
               end else if (hdr_bad) state <= DROP;
            DATA: begin
               lout <= ser_in ? mask : '0;
               lout_act <= mask;
               if (pay_last) begin
                  state <= IDLE;
                  done <= 1'b1;
               end
            end
            DROP:
               if (pay_last) begin
                  state <= IDLE;
                  err <= 1'b1;
               end
         endcase
      end
endmodule
